serial_mac_ctrl: RTL
====================

// Module: serial_mac_ctrl
// PURPOSE
//  Bit-serial multiply-accumulate sequencer: ACC <= ACC + A*B, unsigned, computed with a
//  single instance of the fulladder cell time-shared over every bit of every partial product.
//  Shift-add multiply. Each set multiplier bit triggers one ACCW-cycle serial add pass.
//  Sits between the MAC operand source (START/A/B) and the result consumer (ACC/DONE).
// PARAMETERS
//  WIDTH  4   operand width of A and B (bits)
//  ACCW   12  accumulator width; must satisfy ACCW >= 2*WIDTH
// PORTS
//  CLK    in   1      clock, rising edge
//  RST    in   1      asynchronous, active-high reset
//  START  in   1      request one MAC op; sampled only in IDLE
//  CLR    in   1      clear accumulator and OVF; sampled only in IDLE
//  A      in   WIDTH  multiplicand, captured on accepted START
//  B      in   WIDTH  multiplier, captured on accepted START
//  BUSY   out  1      high from the cycle after START acceptance until DONE
//  DONE   out  1      one-cycle pulse: ACC updated with the new result
//  ACC    out  ACCW   accumulator result register; changes only on DONE, CLR or RST
//  OVF    out  1      sticky: accumulation wrapped modulo 2^ACCW
// BEHAVIOUR
//  Clock and reset: one clock (CLK). Reset (RST) is asynchronous and active-high.
//  Reset values: BUSY=0, DONE=0, ACC=0, OVF=0, FSM=IDLE, internal shift regs/carry/counters=0.
//  RST mid-operation aborts the op. Outputs drop to their reset values immediately. The result is lost.
//  States:
//   IDLE: accepts START/CLR.
//   EXAM: test multiplier bit p.
//   ADD:  serial add pass, ACCW cycles.
//   NEXT: advance to the next pass.
//   FIN:  write back the result.
//  IDLE behaviour:
//   CLR=1 clears ACC and OVF at the next edge.
//   START=1: MCD <= zero-extend(A); MPR <= B; work reg W <= ACC (0 if CLR also high).
//   START=1 also clears carry, sets p=0, goes to EXAM.
//   CLR and START in the same cycle: clear first, then accumulate onto 0 with OVF=0.
//  EXAM: if MPR[p]=1 go to ADD with bit counter i=0 and carry=0. Else go to NEXT.
//  ADD, each cycle:
//   fulladder inputs A=W[0], B=MCD_rot[0], Ci=carry.
//   W <= {S, W[ACCW-1:1]}; MCD_rot rotates right by 1; carry <= Co; i++.
//   After ACCW cycles (i=ACCW-1) W and MCD_rot are back in original alignment; go to NEXT.
//   If the final Co of the pass is 1, set OVF (wrap modulo 2^ACCW).
//  NEXT: MCD <= MCD<<1 (no loss, since ACCW>=2*WIDTH). If p=WIDTH-1 go to FIN, else p++ and go to EXAM.
//  FIN: ACC <= W; DONE=1 for exactly this cycle; BUSY=0 from the next cycle; go to IDLE.
//  Latency: with k = popcount(B) and START accepted at edge 0, DONE is high in cycle 2*WIDTH + k*ACCW + 1.
//  Throughput: a new START may be issued in the cycle after DONE.
//  START and CLR are ignored (no queueing) while BUSY=1 or DONE=1.
//  A and B may change freely after acceptance.
//  ACC holds its previous value for the whole operation. Partial sums are never visible.
//  Arithmetic is unsigned. The result is truncated to ACCW bits. OVF is cleared only by CLR or RST.
// TESTING (WIDTH=4, ACCW=12)
//  1 RST pulse mid-op -> BUSY=0, DONE=0, ACC=0, OVF=0 immediately; the next START works normally.
//  2 CLR+START, A=3, B=5 -> DONE in cycle 33 after START; ACC=15; OVF=0; BUSY high for cycles 1..32.
//  3 Then START A=15, B=15 -> DONE in cycle 57; ACC=240.
//  4 START A=9, B=0 -> DONE in cycle 9; ACC unchanged.
//  5 CLR, then 19x (A=15, B=15) -> after the 18th op ACC=4050, OVF=0; after the 19th op ACC=179, OVF=1.
//    Then a CLR-only cycle -> ACC=0, OVF=0.
//  6 Pulse START/CLR with new A/B while BUSY -> ignored; result matches the original operands; exactly one DONE pulse.

Source files
------------

// File: rtl/serial_mac_ctrl.sv
// Bit-serial unsigned multiply-accumulate sequencer: ACC <= ACC + A*B using one full-adder
// cell time-shared across every bit of every shift-add partial product.
module serial_mac_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACCW  = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CLR,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [ACCW-1:0]  ACC,
  output logic             OVF
);

  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IW = (ACCW > 1) ? $clog2(ACCW) : 1;
  localparam logic [PW-1:0] PLast = PW'(WIDTH - 1);
  localparam logic [IW-1:0] ILast = IW'(ACCW - 1);

  typedef enum logic [2:0] {StIdle, StExam, StAdd, StNext, StFin} state_e;

  state_e            state_q, state_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [ACCW-1:0]   w_q, w_d;
  logic [ACCW-1:0]   mcd_q, mcd_d;
  logic [WIDTH-1:0]  mpr_q, mpr_d;
  logic              carry_q, carry_d;
  logic [PW-1:0]     p_q, p_d;
  logic [IW-1:0]     i_q, i_d;
  logic              fa_s, fa_co;

  // The single full-adder cell shared by every add pass.
  always_comb begin
    fa_s  = w_q[0] ^ mcd_q[0] ^ carry_q;
    fa_co = (w_q[0] & mcd_q[0]) | (w_q[0] & carry_q) | (mcd_q[0] & carry_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (START) state_d = StExam;
      StExam:  state_d = mpr_q[p_q] ? StAdd : StNext;
      StAdd:   if (i_q == ILast) state_d = StNext;
      StNext:  state_d = (p_q == PLast) ? StFin : StExam;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    BUSY = (state_q == StExam) || (state_q == StAdd) || (state_q == StNext);
    DONE = (state_q == StFin);
    ACC  = acc_q;
    OVF  = ovf_q;
  end

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    w_d     = w_q;
    mcd_d   = mcd_q;
    mpr_d   = mpr_q;
    carry_d = carry_q;
    p_d     = p_q;
    i_d     = i_q;
    case (state_q)
      StIdle: begin
        if (CLR) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (START) begin
          mcd_d   = ACCW'(A);
          mpr_d   = B;
          w_d     = CLR ? '0 : acc_q;
          carry_d = 1'b0;
          p_d     = '0;
        end
      end
      StExam: begin
        i_d     = '0;
        carry_d = 1'b0;
      end
      StAdd: begin
        // W and the multiplicand both rotate right, so after ACCW steps they realign.
        w_d     = {fa_s, w_q[ACCW-1:1]};
        mcd_d   = {mcd_q[0], mcd_q[ACCW-1:1]};
        carry_d = fa_co;
        i_d     = i_q + IW'(1);
        if ((i_q == ILast) && fa_co) ovf_d = 1'b1;
      end
      StNext: begin
        mcd_d = mcd_q << 1;
        if (p_q != PLast) p_d = p_q + PW'(1);
      end
      StFin: begin
        acc_d = w_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      w_q     <= '0;
      mcd_q   <= '0;
      mpr_q   <= '0;
      carry_q <= 1'b0;
      p_q     <= '0;
      i_q     <= '0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      w_q     <= w_d;
      mcd_q   <= mcd_d;
      mpr_q   <= mpr_d;
      carry_q <= carry_d;
      p_q     <= p_d;
      i_q     <= i_d;
    end
  end

endmodule
